tlc_vehicle_detector: RTL and testbench
=======================================

Name: tlc_vehicle_detector

Overview:
- Farm-road vehicle detector: the sensing end of the traffic-light controller's car-request input C.
- Synchronises and debounces a raw loop-sensor signal and counts waiting vehicles.
- Drives car_req into the controller's C input. Watches the controller's farm-light output to drain the queue while farm is green.
- Flags sensor overflow and illegal light codes for debug.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed before the debounced sensor changes (range 1..15).
- SERVICE_CYCLES, 3, farm-green cycles per departing vehicle (range 1..15).
- MAX_QUEUE, 15, saturation value of the vehicle count (must fit in 4 bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sensor_raw  in  1  asynchronous raw loop sensor, high while a vehicle is present
- light_farm  in  3  controller farm light, one-hot: 001 green, 010 yellow, 100 red
- car_req  out  1  vehicle request to controller C input
- queue_cnt  out  4  vehicles waiting
- det_state  out  2  FSM state: 0 IDLE, 1 WAIT, 2 SERVE
- overflow  out  1  sticky: arrival seen while queue_cnt == MAX_QUEUE
- bad_light  out  1  sticky: light_farm not one-hot

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - All state updates on the rising edge of clk.
- Reset (rst high at an edge):
  - queue_cnt = 0, det_state = IDLE, car_req = 0, overflow = 0, bad_light = 0.
  - Sync flops, debounced sensor, debounce counter and service timer all cleared to 0.
  - Reset mid-queue discards all pending vehicles.
- Input synchronisation:
  - sensor_raw passes through a 2-flop synchroniser giving s_sync.
- Debounce:
  - A counter increments while s_sync != s_db and clears to 0 when they are equal.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, s_db takes s_sync and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach s_db.
- Arrival:
  - arrive = s_db & ~s_db_q, a one-cycle pulse on the rising edge of s_db.
  - Falling edges of s_db are ignored.
- Service timer:
  - Counts only while light_farm == 001.
  - Clears whenever light_farm != 001, and also at terminal count.
  - depart pulses on the cycle the timer equals SERVICE_CYCLES-1 and queue_cnt > 0.
- queue_cnt update:
  - arrive only: +1. If already MAX_QUEUE, hold the value and set overflow.
  - depart only: -1. Never underflows, because depart requires queue_cnt > 0.
  - arrive and depart in the same cycle: unchanged.
- car_req:
  - Combinational: (queue_cnt != 0).
  - Latency from a clean sensor_raw rise, with queue initially 0: car_req goes high on the DEBOUNCE_CYCLES+3-th rising edge (7 with defaults).
- FSM det_state:
  - IDLE:
    - arrive and light_farm == 001 -> SERVE.
    - arrive otherwise -> WAIT.
  - WAIT:
    - light_farm == 001 -> SERVE.
  - SERVE, leaving when light_farm != 001:
    - queue_cnt (next value) > 0 -> WAIT.
    - queue_cnt (next value) == 0 -> IDLE.
  - SERVE stays SERVE while farm is green, even with an empty queue.
  - Unused encoding 3 -> IDLE.
- bad_light:
  - Set on any cycle where light_farm is not in {001, 010, 100}.
  - Sticky until rst.
  - Queue and FSM treat an illegal code as "not green".

Decomposition:
- Shared package tlc_pkg:
  - Farm/highway light codes (GREEN 3'b001, YELLOW 3'b010, RED 3'b100).
  - Detector state encodings IDLE/WAIT/SERVE.
  - Controller state encodings, so both ends share one definition.
- One sub-module is natural: tlc_debounce (synchroniser + debounce counter + rising-edge pulse, parameterised by DEBOUNCE_CYCLES).
- Queue counter, service timer and FSM stay in the top.

Test Plan:
- Reset/idle: assert rst 2 cycles, release, hold sensor_raw = 0, light_farm = 100 for 20 cycles -> queue_cnt = 0, car_req = 0, det_state = 0, flags 0.
- Debounce latency/glitch:
  - sensor_raw 1-cycle and 3-cycle pulses -> queue_cnt stays 0.
  - A 10-cycle pulse -> car_req rises exactly 7 edges after sensor_raw rises; queue_cnt = 1; det_state = WAIT.
- Service drain:
  - Queue 3 vehicles with light_farm = 100, then drive 001 for 12 cycles.
  - Expect queue_cnt 3 -> 2 -> 1 -> 0 at 3-cycle intervals; car_req falls; det_state = SERVE.
  - Drive 100 -> det_state = IDLE.
- Simultaneous events: with queue_cnt = 2 and farm green, time an arrival on a depart cycle -> queue_cnt stays 2 that cycle.
- Saturation: generate 16 arrivals with farm red -> queue_cnt = 15; overflow = 1 after the 16th; car_req = 1.
- Illegal light / reset mid-operation:
  - Drive light_farm = 011 for 1 cycle -> bad_light = 1 and sticky; no departures.
  - Assert rst with queue_cnt = 5 -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller and its farm-road vehicle detector.
package tlc_pkg;

  localparam logic [2:0] LightGreen  = 3'b001;
  localparam logic [2:0] LightYellow = 3'b010;
  localparam logic [2:0] LightRed    = 3'b100;

  typedef enum logic [1:0] {
    DetIdle  = 2'd0,
    DetWait  = 2'd1,
    DetServe = 2'd2
  } det_state_e;

  typedef enum logic [1:0] {
    CtlHwyGreen   = 2'd0,
    CtlHwyYellow  = 2'd1,
    CtlFarmGreen  = 2'd2,
    CtlFarmYellow = 2'd3
  } ctl_state_e;

  function automatic logic light_is_legal(logic [2:0] code);
    return (code == LightGreen) || (code == LightYellow) || (code == LightRed);
  endfunction

endpackage

// File: rtl/tlc_vehicle_detector_if.sv
// Sensor/light inputs and request/status outputs of the farm-road vehicle detector.
interface tlc_vehicle_detector_if;
  logic       sensor_raw;
  logic [2:0] light_farm;
  logic       car_req;
  logic [3:0] queue_cnt;
  logic [1:0] det_state;
  logic       overflow;
  logic       bad_light;

  modport master (
    output sensor_raw, light_farm,
    input  car_req, queue_cnt, det_state, overflow, bad_light
  );

  modport slave (
    input  sensor_raw, light_farm,
    output car_req, queue_cnt, det_state, overflow, bad_light
  );
endinterface

// File: rtl/tlc_debounce.sv
// Two-flop synchroniser, stability-count debouncer and rising-edge arrival pulse.
module tlc_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_raw,
  output logic arrive
);

  localparam logic [3:0] DbTarget = 4'(DEBOUNCE_CYCLES);

  logic       sync1_q, s_sync_q;
  logic       s_db_q, s_db_d, s_db_prev_q;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = 4'd0;
    s_db_d = s_db_q;
    if (s_sync_q != s_db_q) begin
      // The counter clears on the same edge that the debounced value flips.
      if (cnt_q + 4'd1 == DbTarget) begin
        s_db_d = s_sync_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      s_sync_q    <= 1'b0;
      s_db_q      <= 1'b0;
      s_db_prev_q <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      sync1_q     <= sensor_raw;
      s_sync_q    <= sync1_q;
      s_db_q      <= s_db_d;
      s_db_prev_q <= s_db_q;
      cnt_q       <= cnt_d;
    end
  end

  assign arrive = s_db_q & ~s_db_prev_q;

endmodule

// File: rtl/tlc_vehicle_detector.sv
// Farm-road vehicle detector: counts waiting cars, drains them on farm green, drives car_req.
module tlc_vehicle_detector
  import tlc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SERVICE_CYCLES  = 3,
  parameter int unsigned MAX_QUEUE       = 15
) (
  input logic                  clk,
  input logic                  rst,
  tlc_vehicle_detector_if.slave det
);

  localparam logic [3:0] SvcLast = 4'(SERVICE_CYCLES - 1);
  localparam logic [3:0] MaxQ    = 4'(MAX_QUEUE);

  logic       arrive, depart, green;
  logic [3:0] timer_q, timer_d;
  logic [3:0] queue_q, queue_d;
  logic       overflow_q, overflow_d;
  logic       bad_light_q, bad_light_d;
  det_state_e state_q, state_d;

  tlc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .sensor_raw(det.sensor_raw),
    .arrive    (arrive)
  );

  // Illegal light codes count as not green.
  assign green  = (det.light_farm == LightGreen);
  assign depart = green && (timer_q == SvcLast) && (queue_q != 4'd0);

  always_comb begin
    timer_d = 4'd0;
    if (green && (timer_q != SvcLast)) begin
      timer_d = timer_q + 4'd1;
    end
  end

  always_comb begin
    queue_d     = queue_q;
    overflow_d  = overflow_q;
    bad_light_d = bad_light_q | ~light_is_legal(det.light_farm);
    if (arrive && !depart) begin
      if (queue_q == MaxQ) begin
        overflow_d = 1'b1;
      end else begin
        queue_d = queue_q + 4'd1;
      end
    end else if (depart && !arrive) begin
      queue_d = queue_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DetIdle:  if (arrive) state_d = green ? DetServe : DetWait;
      DetWait:  if (green) state_d = DetServe;
      DetServe: if (!green) state_d = (queue_d != 4'd0) ? DetWait : DetIdle;
      default:  state_d = DetIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q     <= 4'd0;
      queue_q     <= 4'd0;
      overflow_q  <= 1'b0;
      bad_light_q <= 1'b0;
      state_q     <= DetIdle;
    end else begin
      timer_q     <= timer_d;
      queue_q     <= queue_d;
      overflow_q  <= overflow_d;
      bad_light_q <= bad_light_d;
      state_q     <= state_d;
    end
  end

  assign det.car_req   = (queue_q != 4'd0);
  assign det.queue_cnt = queue_q;
  assign det.det_state = state_q;
  assign det.overflow  = overflow_q;
  assign det.bad_light = bad_light_q;

endmodule

// File: tb/tb_tlc_vehicle_detector.sv
// Directed bench for the vehicle detector with a cycle model and per-cycle output comparison.
module tb_tlc_vehicle_detector;

  localparam int Deb  = 4;
  localparam int Svc  = 3;
  localparam int MaxQ = 15;

  logic clk = 1'b0;
  logic rst;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  tlc_vehicle_detector_if dif ();

  tlc_vehicle_detector #(
    .DEBOUNCE_CYCLES(Deb),
    .SERVICE_CYCLES (Svc),
    .MAX_QUEUE      (MaxQ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .det(dif)
  );

  always #5 clk = ~clk;

  // Model state: synchroniser taps, debounced level, stable-run length, queue, FSM, flags.
  int m_s1, m_s2, m_db, m_db_prev, m_run, m_grun, m_q, m_state, m_ovf, m_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit arr, dep, green;
    int qn, sn;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_db_prev = 0; m_run = 0; m_grun = 0;
      m_q = 0; m_state = 0; m_ovf = 0; m_bad = 0;
      return;
    end
    green = (dif.light_farm == 3'b001);
    arr   = (m_db == 1) && (m_db_prev == 0);
    // Departures happen every Svc-th consecutive green cycle.
    dep   = green && ((m_grun % Svc) == Svc - 1) && (m_q > 0);
    qn = m_q;
    if (arr && !dep) begin
      if (m_q == MaxQ) m_ovf = 1;
      else qn = m_q + 1;
    end else if (dep && !arr) begin
      qn = m_q - 1;
    end
    sn = m_state;
    if (m_state == 0 && arr) sn = green ? 2 : 1;
    else if (m_state == 1 && green) sn = 2;
    else if (m_state == 2 && !green) sn = (qn > 0) ? 1 : 0;
    if (!(dif.light_farm inside {3'b001, 3'b010, 3'b100})) m_bad = 1;
    m_grun    = green ? m_grun + 1 : 0;
    m_db_prev = m_db;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == Deb) begin
        m_db  = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = int'(dif.sensor_raw);
    m_q = qn;
    m_state = sn;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic add_vehicle();
    dif.sensor_raw = 1'b1;
    repeat (8) cycle();
    dif.sensor_raw = 1'b0;
    repeat (8) cycle();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("car_req", dif.car_req, (m_q != 0));
      chk("queue_cnt", dif.queue_cnt, m_q);
      chk("det_state", dif.det_state, m_state);
      chk("overflow", dif.overflow, m_ovf);
      chk("bad_light", dif.bad_light, m_bad);
    end
  end

  initial begin
    int first;
    rst = 1'b1;
    dif.sensor_raw = 1'b0;
    dif.light_farm = 3'b100;
    cycle();
    chk_en = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (20) cycle();
    chk("idle_queue", dif.queue_cnt, 0);
    chk("idle_state", dif.det_state, 0);
    chk("idle_req", dif.car_req, 0);

    // Short glitches must be filtered out.
    dif.sensor_raw = 1'b1; cycle(); dif.sensor_raw = 1'b0; repeat (10) cycle();
    dif.sensor_raw = 1'b1; repeat (3) cycle(); dif.sensor_raw = 1'b0; repeat (10) cycle();
    chk("glitch_queue", dif.queue_cnt, 0);

    dif.sensor_raw = 1'b1;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (first == 0 && dif.car_req === 1'b1) first = i;
    end
    dif.sensor_raw = 1'b0;
    repeat (10) cycle();
    chk("req_latency", first, 7);
    chk("one_queue", dif.queue_cnt, 1);
    chk("one_state", dif.det_state, 1);

    add_vehicle();
    add_vehicle();
    chk("three_queue", dif.queue_cnt, 3);
    dif.light_farm = 3'b001;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      chk("drain_queue", dif.queue_cnt, (3 - i / 3 > 0) ? 3 - i / 3 : 0);
    end
    chk("drain_req", dif.car_req, 0);
    chk("drain_state", dif.det_state, 2);
    dif.light_farm = 3'b100;
    cycle();
    chk("leave_state", dif.det_state, 0);

    // Arrival pulse lands on the edge of the first departure.
    add_vehicle();
    add_vehicle();
    dif.sensor_raw = 1'b1;
    repeat (4) cycle();
    dif.light_farm = 3'b001;
    repeat (2) cycle();
    chk("simul_pre", dif.queue_cnt, 2);
    cycle();
    chk("simul_queue", dif.queue_cnt, 2);
    dif.light_farm = 3'b100;
    dif.sensor_raw = 1'b0;
    repeat (8) cycle();
    chk("simul_after", dif.queue_cnt, 2);
    chk("simul_state", dif.det_state, 1);

    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 15; i++) add_vehicle();
    chk("sat15_queue", dif.queue_cnt, 15);
    chk("sat15_ovf", dif.overflow, 0);
    add_vehicle();
    chk("sat16_queue", dif.queue_cnt, 15);
    chk("sat16_ovf", dif.overflow, 1);
    chk("sat16_req", dif.car_req, 1);

    dif.light_farm = 3'b011;
    cycle();
    dif.light_farm = 3'b100;
    repeat (5) cycle();
    chk("bad_sticky", dif.bad_light, 1);
    chk("bad_queue", dif.queue_cnt, 15);

    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 5; i++) add_vehicle();
    chk("five_queue", dif.queue_cnt, 5);
    rst = 1'b1;
    cycle();
    chk("rst_queue", dif.queue_cnt, 0);
    chk("rst_req", dif.car_req, 0);
    chk("rst_state", dif.det_state, 0);
    chk("rst_ovf", dif.overflow, 0);
    chk("rst_bad", dif.bad_light, 0);
    rst = 1'b0;
    repeat (4) cycle();

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
